// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared definitions for the frame-synchronous VGA mode
//               scheduler. Contains mode indices, the pending-request
//               encoding, the scheduler state encoding and the mode step
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Display mode indices; bit N of the one-hot mode bus selects mode N
    localparam int MODE_WHITE   = 0;
    localparam int MODE_BLACK   = 1;
    localparam int MODE_RED     = 2;
    localparam int MODE_GREEN   = 3;
    localparam int MODE_MONITOR = 4;
    localparam int MODE_CHAR    = 5;

    localparam int NUM_MODES_DEFAULT = 6;

    // Direction of a latched mode-change request
    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_NEXT = 2'd1,
        PEND_PREV = 2'd2
    } pend_dir_t;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } sched_state_t;

    // Step a mode index one place in the given direction, wrapping within n modes
    function automatic logic [2:0] mode_step(input logic [2:0] idx,
                                             input pend_dir_t  dir,
                                             input int unsigned n);
        logic [2:0] last;
        last      = 3'(n - 1);
        mode_step = idx;
        if (dir == PEND_NEXT) begin
            mode_step = (idx == last) ? 3'd0 : idx + 3'd1;
        end else if (dir == PEND_PREV) begin
            mode_step = (idx == 3'd0) ? last : idx - 3'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_tick.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_tick
// Description : Vertical-sync assertion-edge detector. Produces a one-cycle
//               registered frame_tick on the cycle after the clock edge that
//               first samples vsync at its active level.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_tick #(
    parameter logic VSYNC_ACT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic frame_tick
);

    logic r_vs_q;
    logic r_tick;

    // Register vsync and flag its transition into the active level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_q <= ~VSYNC_ACT;
            r_tick <= 1'b0;
        end else begin
            r_vs_q <= vsync;
            r_tick <= (vsync == VSYNC_ACT) && (r_vs_q != VSYNC_ACT);
        end
    end

    assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/vga_mode_sched.sv
`default_nettype none
// ============================================================================
// Module      : vga_mode_sched
// Description : Frame-synchronous display-mode scheduler. Latches next/prev
//               key requests and applies them only at a vertical-sync
//               boundary, driving a one-hot mode bus for the pixel generator.
//               Optional auto-cycle is enabled by defining the macro
//               VGA_MODE_AUTO_CYCLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_mode_sched
    import vga_pkg::*;
#(
    parameter int   NUM_MODES   = NUM_MODES_DEFAULT,
    parameter logic VSYNC_ACT   = 1'b0,
    parameter int   AUTO_FRAMES = 120
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vsync,
    input  logic                 key_next,
    input  logic                 key_prev,
    input  logic                 key_auto,
    output logic [NUM_MODES-1:0] vga_state,
    output logic [2:0]           mode_idx,
    output logic                 switch_pulse,
    output logic                 auto_active
);

    logic         w_tick;
    sched_state_t r_state, w_state_nxt;
    pend_dir_t    r_pend, w_pend_nxt;
    pend_dir_t    r_apply_dir, w_apply_dir_nxt;
    pend_dir_t    w_key_req;
    logic [2:0]   r_mode;
    logic         r_switch;
    logic         w_auto_fire;

    vga_frame_tick #(
        .VSYNC_ACT (VSYNC_ACT)
    ) u_frame_tick (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .frame_tick (w_tick)
    );

    // Decode keys into a request; simultaneous next+prev cancel out
    always_comb begin
        w_key_req = PEND_NONE;
        if (key_next && !key_prev) begin
            w_key_req = PEND_NEXT;
        end else if (key_prev && !key_next) begin
            w_key_req = PEND_PREV;
        end
    end

`ifdef VGA_MODE_AUTO_CYCLE_EN
    logic        r_auto;
    logic [15:0] r_frame_cnt;
    logic        w_cnt_last;

    assign w_cnt_last  = (r_frame_cnt == 16'(AUTO_FRAMES - 1));
    // Auto advance only fires when no manual request is held or arriving
    assign w_auto_fire = r_auto && w_tick && w_cnt_last &&
                         (r_state == ST_IDLE) && (w_key_req == PEND_NONE);

    // Toggle auto-cycle enable on each key_auto pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto <= 1'b0;
        end else if (key_auto) begin
            r_auto <= ~r_auto;
        end
    end

    // Count frames while auto is on; any apply restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if (!r_auto || (r_state == ST_APPLY)) begin
            r_frame_cnt <= 16'd0;
        end else if (w_tick) begin
            r_frame_cnt <= w_cnt_last ? 16'd0 : r_frame_cnt + 16'd1;
        end
    end

    assign auto_active = r_auto;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = key_auto | (AUTO_FRAMES == 0);
    assign w_auto_fire  = 1'b0;
    assign auto_active  = 1'b0;
`endif

    // Scheduler state, held request and direction being applied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pend      <= PEND_NONE;
            r_apply_dir <= PEND_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_apply_dir <= w_apply_dir_nxt;
        end
    end

    // Next-state logic; a request seen together with a tick waits a frame
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_nxt      = r_pend;
        w_apply_dir_nxt = r_apply_dir;
        case (r_state)
            ST_IDLE: begin
                if (w_key_req != PEND_NONE) begin
                    w_pend_nxt  = w_key_req;
                    w_state_nxt = ST_PEND;
                end else if (w_auto_fire) begin
                    w_apply_dir_nxt = PEND_NEXT;
                    w_state_nxt     = ST_APPLY;
                end
            end
            ST_PEND: begin
                if (w_tick) begin
                    w_apply_dir_nxt = r_pend;
                    w_pend_nxt      = w_key_req;
                    w_state_nxt     = ST_APPLY;
                end else if (w_key_req != PEND_NONE) begin
                    w_pend_nxt = w_key_req;
                end
            end
            ST_APPLY: begin
                if (w_key_req != PEND_NONE) begin
                    w_pend_nxt = w_key_req;
                end
                w_state_nxt = (w_pend_nxt != PEND_NONE) ? ST_PEND : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pend_nxt  = PEND_NONE;
            end
        endcase
    end

    // Update the visible mode at the end of the apply cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= 3'(MODE_WHITE);
            r_switch <= 1'b0;
        end else begin
            r_switch <= (r_state == ST_APPLY);
            if (r_state == ST_APPLY) begin
                r_mode <= mode_step(r_mode, r_apply_dir, NUM_MODES);
            end
        end
    end

    assign mode_idx     = r_mode;
    assign vga_state    = {{(NUM_MODES-1){1'b0}}, 1'b1} << r_mode;
    assign switch_pulse = r_switch;

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_mode_sched
// Description : Self-checking bench for vga_mode_sched with a frame-level
//               reference model and directed key/vsync scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mode_sched;

    localparam int N  = 6;
    localparam int AF = 3;
`ifdef VGA_MODE_AUTO_CYCLE_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         vsync;
    logic         key_next;
    logic         key_prev;
    logic         key_auto;
    logic [N-1:0] vga_state;
    logic [2:0]   mode_idx;
    logic         switch_pulse;
    logic         auto_active;

    int n_checks = 0;
    int n_pass   = 0;
    int sw_count = 0;
    int sw_snap;

    always #5 clk = ~clk;

    vga_mode_sched #(
        .NUM_MODES   (N),
        .VSYNC_ACT   (1'b0),
        .AUTO_FRAMES (AF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .key_next     (key_next),
        .key_prev     (key_prev),
        .key_auto     (key_auto),
        .vga_state    (vga_state),
        .mode_idx     (mode_idx),
        .switch_pulse (switch_pulse),
        .auto_active  (auto_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level rules) ----------------
    // A boundary is the clock edge after the one that first sees vsync low.
    // Requests held at a boundary become visible one edge later.
    int m_mode, m_pend, m_dir, m_cnt, m_key;
    bit m_due, m_switch, m_auto, m_vs_prev, m_edge_seen, m_boundary, m_applying;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pend = 0; m_dir = 0; m_cnt = 0;
            m_due = 0; m_switch = 0; m_auto = 0;
            m_vs_prev = 1; m_edge_seen = 0;
        end else begin
            m_boundary  = m_edge_seen;
            m_edge_seen = (vsync == 1'b0) && m_vs_prev;
            m_vs_prev   = vsync;
            m_applying  = m_due;
            m_switch    = 0;
            if (m_due) begin
                m_mode   = (m_dir == 1) ? (m_mode + 1) % N : (m_mode + N - 1) % N;
                m_switch = 1;
                m_due    = 0;
            end
            m_key = (key_next && !key_prev) ? 1 : ((key_prev && !key_next) ? 2 : 0);
            if (m_boundary) begin
                if (m_pend != 0) begin
                    m_due = 1; m_dir = m_pend; m_pend = 0;
                end else if (m_auto && m_cnt == AF - 1 && m_key == 0) begin
                    m_due = 1; m_dir = 1;
                end
            end
            if (!m_auto || m_applying) m_cnt = 0;
            else if (m_boundary) m_cnt = (m_cnt == AF - 1) ? 0 : m_cnt + 1;
            if (m_key != 0) m_pend = m_key;
            if (AUTO_EN && key_auto) m_auto = !m_auto;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        check("model_vga_state", 32'(vga_state), 32'(1) << m_mode);
        check("model_mode_idx", 32'(mode_idx), 32'(m_mode));
        check("model_switch", 32'(switch_pulse), 32'(m_switch));
        check("model_auto", 32'(auto_active), 32'(m_auto));
        if (switch_pulse) sw_count++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit n, input bit p, input bit a);
        key_next = n; key_prev = p; key_auto = a;
        step();
        key_next = 0; key_prev = 0; key_auto = 0;
    endtask

    task automatic frame();
        repeat (6) step();
        vsync = 1'b0;
        repeat (3) step();
        vsync = 1'b1;
        repeat (6) step();
    endtask

    initial begin
        rst = 1; vsync = 1; key_next = 0; key_prev = 0; key_auto = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        check("reset_vga_state", 32'(vga_state), 32'h01);
        check("reset_mode_idx", 32'(mode_idx), 32'd0);
        check("reset_switch", 32'(switch_pulse), 32'd0);
        check("reset_auto", 32'(auto_active), 32'd0);

        // Idle frames: nothing changes
        repeat (3) frame();
        check("idle_vga_state", 32'(vga_state), 32'h01);
        check("idle_no_switch", 32'(sw_count), 32'd0);

        // Exact latency of a next request
        repeat (3) step();
        pulse(1, 0, 0);
        repeat (3) step();
        vsync = 1'b0;
        step();
        check("lat_edge0", 32'(vga_state), 32'h01);
        step();
        check("lat_edge1", 32'(vga_state), 32'h01);
        step();
        check("lat_edge2_state", 32'(vga_state), 32'h02);
        check("lat_edge2_pulse", 32'(switch_pulse), 32'd1);
        vsync = 1'b1;
        step();
        check("lat_edge3_pulse", 32'(switch_pulse), 32'd0);
        repeat (6) step();

        // Wrap-around in both directions
        pulse(0, 1, 0); frame();
        check("prev_to_white", 32'(mode_idx), 32'd0);
        pulse(0, 1, 0); frame();
        check("prev_wrap_idx", 32'(mode_idx), 32'd5);
        check("prev_wrap_state", 32'(vga_state), 32'h20);
        pulse(1, 0, 0); frame();
        check("next_wrap_idx", 32'(mode_idx), 32'd0);

        // Last request wins, single apply
        sw_snap = sw_count;
        pulse(1, 0, 0); repeat (2) step(); pulse(0, 1, 0); frame();
        check("last_wins_idx", 32'(mode_idx), 32'd5);
        check("last_wins_one_pulse", 32'(sw_count), 32'(sw_snap + 1));

        // Simultaneous keys are ignored
        sw_snap = sw_count;
        pulse(1, 1, 0); frame();
        check("both_keys_idx", 32'(mode_idx), 32'd5);
        check("both_keys_no_pulse", 32'(sw_count), 32'(sw_snap));

        // Request in the tick cycle waits for the following frame
        repeat (6) step();
        vsync = 1'b0;
        step();
        pulse(1, 0, 0);
        vsync = 1'b1;
        repeat (8) step();
        check("tick_req_deferred", 32'(mode_idx), 32'd5);
        frame();
        check("tick_req_applied", 32'(mode_idx), 32'd0);

        // Reset while a request is pending discards it
        pulse(1, 0, 0); step();
        rst = 1; step(); step(); rst = 0;
        sw_snap = sw_count;
        frame();
        check("rst_pend_idx", 32'(mode_idx), 32'd0);
        check("rst_pend_no_pulse", 32'(sw_count), 32'(sw_snap));

`ifdef VGA_MODE_AUTO_CYCLE_EN
        pulse(0, 0, 1);
        check("auto_on", 32'(auto_active), 32'd1);
        frame(); check("auto_f1", 32'(mode_idx), 32'd0);
        frame(); check("auto_f2", 32'(mode_idx), 32'd0);
        frame(); check("auto_f3", 32'(mode_idx), 32'd1);
        frame();
        pulse(1, 0, 0); frame();
        check("auto_manual", 32'(mode_idx), 32'd2);
        frame(); check("auto_restart1", 32'(mode_idx), 32'd2);
        frame(); check("auto_restart2", 32'(mode_idx), 32'd2);
        frame(); check("auto_restart3", 32'(mode_idx), 32'd3);
        pulse(0, 0, 1);
        check("auto_off", 32'(auto_active), 32'd0);
        repeat (4) frame();
        check("auto_off_hold", 32'(mode_idx), 32'd3);
`else
        pulse(0, 0, 1);
        check("auto_ignored", 32'(auto_active), 32'd0);
        repeat (4) frame();
        check("auto_ignored_hold", 32'(mode_idx), 32'd0);
`endif

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_mode_sched.md
Name: vga_mode_sched

Overview:
- Frame-synchronous display-mode scheduler for the VGA pipeline.
- Replaces the free-running key-driven mode register in front of the VGA data generator.
- Latches next/previous mode requests from debounced keys and optionally auto-cycles modes every N frames.
- Applies every mode change only at a vertical-sync boundary, so a frame never shows two modes (no tearing).
- Drives the one-hot mode bus consumed by the pixel-data generator.

Parameters:
- NUM_MODES, 6, number of display modes (WHITE, BLACK, RED, GREEN, MONITOR, CHAR); legal range 2..8.
- VSYNC_ACT, 1'b0, active level of the vsync input (640x480 timing is active-low).
- AUTO_FRAMES, 120, frames per mode in auto-cycle; legal range 1..65535.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  asynchronous reset, active-high.
- vsync  input  1  vertical sync from the VGA timing generator.
- key_next  input  1  one-cycle pulse: request the next mode.
- key_prev  input  1  one-cycle pulse: request the previous mode.
- key_auto  input  1  one-cycle pulse: toggle auto-cycle (ignored without AUTO_CYCLE_EN).
- vga_state  output  NUM_MODES  one-hot current mode; bit 0 = WHITE.
- mode_idx  output  3  binary index of the current mode.
- switch_pulse  output  1  high for one cycle on the cycle a new mode becomes visible.
- auto_active  output  1  auto-cycle is enabled.

Behaviour:
- Reset (async, rst=1): vga_state=1 (WHITE), mode_idx=0, switch_pulse=0, auto_active=0, pending cleared, frame counter=0, vs_q=inactive.
- Frame tick:
  - vs_q registers vsync.
  - frame_tick = (vsync==VSYNC_ACT) && (vs_q!=VSYNC_ACT), i.e. the assertion edge, which falls in vertical blanking.
- Request latch:
  - Inputs: key_next/key_prev sampled each clock.
  - key_next alone sets pending=NEXT; key_prev alone sets pending=PREV.
  - Both in the same cycle: ignored, pending unchanged.
  - A newer request overwrites an older one (last wins); requests do not accumulate.
- FSM states:
  - IDLE: no pending request. Any accepted request goes to PEND.
  - PEND: request held until frame_tick, then goes to APPLY.
  - APPLY: one cycle; mode register updates, switch_pulse=1, then returns to IDLE.
  - A request arriving in the cycle frame_tick is high still goes to PEND and waits for the next frame.
  - A request arriving during APPLY is captured into PEND.
- Latency: vga_state changes 2 clocks after the clock edge that samples vsync assertion (tick cycle + APPLY cycle). switch_pulse is coincident with the new vga_state value.
- Wrap-around:
  - NEXT from NUM_MODES-1 goes to 0.
  - PREV from 0 goes to NUM_MODES-1.
  - mode_idx is always < NUM_MODES. vga_state = 1 << mode_idx.
- No pending request: vga_state is held indefinitely.
- vsync stuck (held active or inactive): no ticks occur, so pending waits forever; this is legal.
- Reset mid-PEND: request discarded.

Optional Feature:
- Macro: VGA_MODE_AUTO_CYCLE_EN.
- When defined:
  - key_auto toggles auto_active.
  - 16-bit frame counter increments on each frame_tick while auto_active=1.
  - When the counter reaches AUTO_FRAMES-1 on a tick and nothing is pending, it forces a NEXT apply (same APPLY path) and clears to 0.
  - A manual apply also clears the counter.
  - Disabling auto clears the counter.
- When undefined: auto_active is tied to 0, key_auto is ignored, and no counter logic is present.

Decomposition:
- Shared package vga_pkg holds:
  - mode index localparams (MODE_WHITE=0 .. MODE_CHAR=5);
  - the NUM_MODES default;
  - the pending-direction encoding (PEND_NONE, PEND_NEXT, PEND_PREV);
  - the FSM state encoding.
- One sub-module: vga_frame_tick (vsync edge detector, parameter VSYNC_ACT), reusable by other frame-synchronous blocks.

Test Plan:
- Reset, then 3 frames with no keys -> vga_state=6'b000001 throughout, switch_pulse never asserted.
- key_next pulsed mid-frame -> vga_state stays 000001 until vsync assertion, becomes 000010 exactly 2 clks after the sampling edge, switch_pulse one cycle.
- key_prev at mode 0 -> mode_idx=5 (CHAR) at next frame; key_next at mode 5 -> mode_idx=0.
- key_next then key_prev within one frame -> single PREV apply; key_next and key_prev in the same cycle -> no change.
- key_next in the frame_tick cycle -> applied at the following frame, not the current one; rst asserted while PEND -> mode 0, no apply afterwards.
- VGA_MODE_AUTO_CYCLE_EN, AUTO_FRAMES=3, key_auto pulsed -> auto_active=1, mode advances every 3rd tick; key_next mid-run restarts the count; second key_auto -> auto_active=0, modes hold.
